// File: rtl/mandel_pkg.sv
// Shared types and constants for the Mandelbrot/Julia iteration scheduler.
package mandel_pkg;
  localparam int W         = 16;
  localparam int FRAC      = 12;
  localparam int H_CENTER  = 640;
  localparam int V_CENTER  = 360;
  localparam int PIX_SHIFT = 4;
  localparam logic [2*W:0] THR = (2*W+1)'(4) << FRAC;

  typedef struct packed {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  // Pixel offset from centre, scaled into fixed point; wraps to W bits.
  function automatic logic signed [W-1:0] pix_map(input logic [11:0] p, input int center);
    int d;
    d = int'(p) - center;
    return W'(d <<< PIX_SHIFT);
  endfunction
endpackage

// File: rtl/mandel_step.sv
// One combinational z <- z^2 + c step plus the |z|^2 >= THR escape test on the current z.
module mandel_step
  import mandel_pkg::*;
#(
  parameter logic [2*W:0] THR_P = THR
) (
  input  cplx_t z,
  input  cplx_t c,
  output cplx_t z_next,
  output logic  esc
);
  logic signed [2*W-1:0] zr_x, zi_x, rr, ii, ri;
  logic signed [2*W:0]   diff;
  logic        [2*W:0]   mag;

  assign zr_x = z.re;
  assign zi_x = z.im;
  assign rr   = zr_x * zr_x;
  assign ii   = zi_x * zi_x;
  assign ri   = zr_x * zi_x;

  assign diff      = {rr[2*W-1], rr} - {ii[2*W-1], ii};
  assign z_next.re = W'(diff >>> FRAC) + c.re;
  // 2*zr*zi folded into a shift one bit short of FRAC
  assign z_next.im = W'(ri >>> (FRAC-1)) + c.im;

  // squares are non-negative, so the sum is taken unsigned with a spare bit
  assign mag = ({1'b0, rr} + {1'b0, ii}) >> FRAC;
  assign esc = mag >= THR_P;
endmodule

// File: rtl/mandel_iter_sched.sv
// Time-shares one mandel_step across pixels: accept, iterate to escape or limit, present count.
// Define MANDEL_JULIA_EN for Julia mode (z0 = pixel, c from iJULIA_CR/iJULIA_CI).
module mandel_iter_sched
  import mandel_pkg::*;
#(
  parameter int           H_CTR = H_CENTER,
  parameter int           V_CTR = V_CENTER,
  parameter logic [2*W:0] THR_P = THR
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iPIX_VALID,
  output logic                oPIX_READY,
  input  logic [11:0]         iPIX_X,
  input  logic [11:0]         iPIX_Y,
  input  logic [7:0]          iMAX_ITER,
  output logic                oRES_VALID,
  input  logic                iRES_READY,
  output logic [7:0]          oRES_ITER,
  output logic                oRES_ESC,
`ifdef MANDEL_JULIA_EN
  input  logic signed [W-1:0] iJULIA_CR,
  input  logic signed [W-1:0] iJULIA_CI,
`endif
  output logic                oBUSY
);
  state_t     state, nxt;
  cplx_t      z, c, z_next, pix;
  logic [7:0] n, lim;
  logic       esc, accept;

  mandel_step #(.THR_P(THR_P)) u_step (
    .z      (z),
    .c      (c),
    .z_next (z_next),
    .esc    (esc)
  );

  assign pix.re     = pix_map(iPIX_X, H_CTR);
  assign pix.im     = pix_map(iPIX_Y, V_CTR);
  assign oPIX_READY = (state == IDLE) && !iRST;
  assign oRES_VALID = (state == DONE);
  assign oBUSY      = (state != IDLE);
  assign accept     = iPIX_VALID && oPIX_READY;

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (iPIX_VALID) nxt = ITER;
      ITER:    if (esc || n == lim) nxt = DONE;
      DONE:    if (iRES_READY) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      z         <= '0;
      c         <= '0;
      n         <= '0;
      lim       <= '0;
      oRES_ITER <= '0;
      oRES_ESC  <= 1'b0;
    end else if (accept) begin
`ifdef MANDEL_JULIA_EN
      z    <= pix;
      c.re <= iJULIA_CR;
      c.im <= iJULIA_CI;
`else
      z    <= '0;
      c    <= pix;
`endif
      n    <= '0;
      lim  <= iMAX_ITER;
    end else if (state == ITER) begin
      // escape outranks the limit, so lim = 0 can still report an escape
      if (esc) begin
        oRES_ITER <= n;
        oRES_ESC  <= 1'b1;
      end else if (n == lim) begin
        oRES_ITER <= lim;
        oRES_ESC  <= 1'b0;
      end else begin
        z <= z_next;
        n <= n + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_mandel_iter_sched.sv
// Scoreboard bench for mandel_iter_sched: random pixels against an arithmetic reference model.
module tb_mandel_iter_sched;
  logic        iCLK = 0, iRST = 1, iPIX_VALID = 0, iRES_READY = 0;
  logic [11:0] iPIX_X = 0, iPIX_Y = 0;
  logic [7:0]  iMAX_ITER = 0;
  logic        oPIX_READY, oRES_VALID, oRES_ESC, oBUSY;
  logic [7:0]  oRES_ITER;
`ifdef MANDEL_JULIA_EN
  logic signed [15:0] iJULIA_CR = 0, iJULIA_CI = 0;
`endif

  mandel_iter_sched dut (
    .iCLK(iCLK), .iRST(iRST), .iPIX_VALID(iPIX_VALID), .oPIX_READY(oPIX_READY),
    .iPIX_X(iPIX_X), .iPIX_Y(iPIX_Y), .iMAX_ITER(iMAX_ITER),
    .oRES_VALID(oRES_VALID), .iRES_READY(iRES_READY), .oRES_ITER(oRES_ITER),
    .oRES_ESC(oRES_ESC),
`ifdef MANDEL_JULIA_EN
    .iJULIA_CR(iJULIA_CR), .iJULIA_CI(iJULIA_CI),
`endif
    .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  typedef struct { int iter; bit esc; } exp_t;
  exp_t exp_q[$];
  int   acc_q[$];
  int   checks = 0, fails = 0, cyc = 0, hold_lo = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic longint wrap16(input longint v);
    return ((v & 65535) ^ 32768) - 32768;
  endfunction

  // Reference: escape radius 2, Q4.12 values held as plain integers.
  task automatic model(input int x, input int y, input int mx, input int jr, input int ji,
                       output int it, output bit e);
    longint pr, pi, zr, zi, cr, ci, t;
    pr = wrap16((x - 640) * 16);
    pi = wrap16((y - 360) * 16);
`ifdef MANDEL_JULIA_EN
    zr = pr; zi = pi; cr = jr; ci = ji;
`else
    zr = 0; zi = 0; cr = pr; ci = pi;
`endif
    for (int n = 0; n <= mx; n++) begin
      if (((zr*zr + zi*zi) >>> 12) >= 16384) begin it = n; e = 1; return; end
      if (n == mx) begin it = mx; e = 0; return; end
      t  = wrap16(((zr*zr - zi*zi) >>> 12) + cr);
      zi = wrap16(((zr*zi) >>> 11) + ci);
      zr = t;
    end
    it = mx; e = 0;
  endtask

  task automatic send(input int x, input int y, input int mx, input int jr, input int ji,
                      input int e_it, input bit e_esc);
    bit ok = 0;
    @(posedge iCLK); #1;
    iPIX_VALID = 1; iPIX_X = 12'(x); iPIX_Y = 12'(y); iMAX_ITER = 8'(mx);
`ifdef MANDEL_JULIA_EN
    iJULIA_CR = 16'(jr); iJULIA_CI = 16'(ji);
`endif
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge iCLK);
      ok = oPIX_READY;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    else exp_q.push_back('{e_it, e_esc});
    @(posedge iCLK); #1;
    // junk on the pixel inputs while busy must not matter
    iPIX_VALID = 0; iPIX_X = 12'($urandom); iPIX_Y = 12'($urandom); iMAX_ITER = 8'($urandom);
`ifdef MANDEL_JULIA_EN
    iJULIA_CR = 16'($urandom); iJULIA_CI = 16'($urandom);
`endif
    if (!ok) $fatal(1, "accept never happened");
  endtask

  task automatic drain();
    int i = 0;
    while (exp_q.size() != 0 && i < 3000) begin @(negedge iCLK); i++; end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    @(negedge iCLK);
  endtask

  always begin
    @(posedge iCLK); #1;
    if (hold_lo > 0) begin iRES_READY = 0; hold_lo--; end
    else iRES_READY = ($urandom % 3) != 0;
  end

  // Monitor: latency, hold-while-stalled, no bypass, return to idle, result values.
  bit prev_v = 0, post_hs = 0;
  logic [7:0] held_it;
  logic       held_esc;
  always @(negedge iCLK) begin
    cyc++;
    if (iRST) begin
      prev_v = 0; post_hs = 0;
    end else begin
      if (iPIX_VALID && oPIX_READY) acc_q.push_back(cyc);
      if (post_hs) begin
        chk("idle_after_hs_busy", oBUSY, 0);
        chk("idle_after_hs_valid", oRES_VALID, 0);
        post_hs = 0;
      end
      if (oRES_VALID) begin
        chk("no_bypass_ready", oPIX_READY, 0);
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          if (!prev_v) chk("latency", cyc - acc_q[0], exp_q[0].iter + 2);
          else begin
            chk("hold_iter", oRES_ITER, held_it);
            chk("hold_esc", oRES_ESC, held_esc);
          end
          held_it = oRES_ITER; held_esc = oRES_ESC;
          if (iRES_READY) begin
            chk("res_iter", oRES_ITER, exp_q[0].iter);
            chk("res_esc", oRES_ESC, exp_q[0].esc);
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            post_hs = 1;
          end
        end
      end
      prev_v = oRES_VALID;
    end
  end

  initial begin
    int it; bit e; int x, y, mx, jr, ji;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    chk("rst_pix_ready", oPIX_READY, 0);
    chk("rst_res_valid", oRES_VALID, 0);
    chk("rst_res_iter", oRES_ITER, 0);
    chk("rst_res_esc", oRES_ESC, 0);
    chk("rst_busy", oBUSY, 0);
    @(posedge iCLK); #1 iRST = 0;

    send(640, 360, 20, 0, 0, 20, 0);
    drain();
    hold_lo = 10;
`ifdef MANDEL_JULIA_EN
    send(1152, 360, 20, 0, 0, 0, 1);
`else
    send(1152, 360, 20, 0, 0, 1, 1);
`endif
    drain();
    send(640, 360, 0, 0, 0, 0, 0);
    drain();

    // abort an iteration in flight at n = 7
    send(640, 360, 200, 0, 0, 200, 0);
    repeat (7) @(posedge iCLK);
    #1 iRST = 1;
    @(posedge iCLK);
    @(negedge iCLK);
    chk("abort_busy", oBUSY, 0);
    chk("abort_valid", oRES_VALID, 0);
    void'(exp_q.pop_back());
    if (acc_q.size() != 0) void'(acc_q.pop_back());
    @(posedge iCLK); #1 iRST = 0;
    repeat (30) @(negedge iCLK);
    model(1152, 360, 20, 0, 0, it, e);
    send(1152, 360, 20, 0, 0, it, e);
    drain();

`ifdef MANDEL_JULIA_EN
    send(1152, 360, 20, 4096, 0, 0, 1);
    drain();
`endif

    for (int k = 0; k < 40; k++) begin
      x  = 128 + int'($urandom % 1025);
      y  = int'($urandom % 720);
      mx = int'($urandom % 41);
      jr = int'($urandom % 8192) - 4096;
      ji = int'($urandom % 8192) - 4096;
      model(x, y, mx, jr, ji, it, e);
      send(x, y, mx, jr, ji, it, e);
      if ($urandom % 4 == 0) hold_lo = int'($urandom % 8);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
